pc_gen: RTL and testbench
=========================

# pc_gen

Next-PC generator that sits directly upstream of the instruction fetch unit (IFU). It holds the architectural fetch PC and offers it to the IFU over a valid/ready handshake. It advances sequentially by 4 on each accepted fetch and applies branch/jump and trap redirects. On a redirect it emits a one-cycle flush to the IFU and halts fetch on a misaligned redirect target.

## Interface
Parameters:
- RESET_VECTOR, 32'h3000_0000, first PC offered after reset.
- PC_STEP, 4, sequential increment in bytes.

Ports:
- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low; clears all state immediately, released synchronously by the integrator.
- redirect_valid  in  1  taken branch/jump resolved downstream, single-cycle pulse.
- redirect_pc  in  32  branch/jump target, sampled when redirect_valid=1.
- trap_valid  in  1  trap entry or mret, single-cycle pulse; higher priority than redirect_valid.
- trap_pc  in  32  trap/return target; bits [1:0] forced to 0 internally.
- pc_out  out  32  PC offered to the IFU (drives IFU pc_in).
- pc_valid  out  1  pc_out is valid (drives IFU in_valid).
- ifu_ready  in  1  IFU accepts a PC (driven by IFU in_ready).
- flush  out  1  one-cycle pulse telling the IFU to drop in-flight work (drives IFU jump).
- misalign  out  1  one-cycle pulse: redirect target was not 4-byte aligned.
- misalign_pc  out  32  offending target, held until the next misalign pulse.

## Operation
- FSM states: BOOT, RUN, HALT.
- Reset values: pc_q=RESET_VECTOR, state=BOOT, pc_valid=0, flush=0, misalign=0, misalign_pc=0.
- BOOT: after one cycle, enter RUN with pc_valid=1 and pc_out=RESET_VECTOR.
- RUN: pc_valid=1.
  - On accept (pc_valid && ifu_ready), pc_q <= pc_q + PC_STEP.
  - The addition is modulo 2^32: 32'hFFFF_FFFC wraps to 0.
- Redirect priority, applied in any state:
  1. trap_valid
  2. redirect_valid
  3. sequential advance
- Trap: pc_q <= {trap_pc[31:2],2'b00}; flush=1 next cycle; state <= RUN (this also leaves HALT).
- Redirect in RUN, target aligned (redirect_pc[1:0]==0): pc_q <= redirect_pc; flush=1 next cycle.
- Redirect in RUN, target misaligned:
  - pc_q is unchanged.
  - misalign=1 and misalign_pc=redirect_pc next cycle.
  - flush=1 next cycle.
  - state <= HALT.
- HALT: pc_valid=0. redirect_valid is ignored. Only trap_valid or reset leaves HALT.
- Redirect/trap in the same cycle as an accept: the accepted PC counts as fetched. The following flush cancels it, and pc_q takes the target, not pc_q+4.
- Redirect/trap during BOOT: the target replaces RESET_VECTOR, then the block enters RUN.
- Reset asserted mid-operation: all outputs return to their reset values asynchronously. A flush pulse in progress is dropped.

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Redirect/trap at cycle N:
  - flush=1 and pc_out=target at cycle N+1.
  - pc_valid=1 at N+1, unless the block enters HALT.
- flush lasts exactly one cycle per redirect. Back-to-back redirects give back-to-back flush pulses.
- Handshake rules:
  - While pc_valid=1 and no redirect occurs, pc_out is stable until accepted.
  - pc_valid never drops without an accept, except on redirect-to-HALT or reset.
- Throughput: one PC per cycle when ifu_ready is held high.
- First valid PC appears 1 cycle after reset release.

## Structure
- Shared package (e.g. pc_pkg):
  - state enum {BOOT, RUN, HALT}
  - RESET_VECTOR default
  - PC_STEP
  - alignment mask constant 2'b00
- No sub-module. Single always-block FSM plus PC register; the target mux sits in front of pc_q.

## Test plan
- Reset then ifu_ready=1 for 4 cycles -> pc_out 3000_0000, 3000_0004, 3000_0008, 3000_000C; flush=0 throughout.
- ifu_ready=0 for 5 cycles at pc_out=3000_0008 -> pc_out held at 3000_0008 with pc_valid=1; advances to 3000_000C one cycle after ifu_ready=1.
- redirect_valid with redirect_pc=8000_0100, same cycle as an accept -> next cycle flush=1, pc_out=8000_0100; then 8000_0104.
- trap_valid (trap_pc=8000_0003) and redirect_valid (8000_0200) in the same cycle -> pc_out=8000_0000, one flush pulse.
- redirect_pc=8000_0102 -> misalign=1, misalign_pc=8000_0102, flush=1, pc_valid=0. A later redirect_valid is ignored; a later trap_pc=8000_1000 -> RUN with pc_out=8000_1000.
- pc_q=FFFF_FFFC accepted -> pc_out=0000_0000. Async reset asserted mid-cycle -> pc_valid=0 immediately; pc_out=3000_0000 after release.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared definitions for the next-PC generator.
//   state_t          : fetch FSM state (BOOT, RUN, HALT)
//   RESET_VECTOR_DEF : default first PC after reset
//   PC_STEP_DEF      : default sequential increment in bytes
//   ALIGN_OK         : value of target bits [1:0] for a 4-byte aligned target
package pc_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  localparam logic [31:0] RESET_VECTOR_DEF = 32'h3000_0000;
  localparam logic [31:0] PC_STEP_DEF      = 32'd4;
  localparam logic [1:0]  ALIGN_OK         = 2'b00;

  function automatic logic is_aligned(input logic [31:0] addr);
    return addr[1:0] == ALIGN_OK;
  endfunction

endpackage

// File: rtl/pc_gen.sv
// Next-PC generator feeding the instruction fetch unit.
// Holds the fetch PC, offers it on a valid/ready handshake, steps by PC_STEP
// on each accept and applies trap/redirect targets with a one-cycle flush.
// A misaligned redirect target halts fetch until a trap arrives.
//
// Ports:
//   clock          in   rising-edge clock
//   reset          in   asynchronous active-low reset
//   redirect_valid in   taken branch/jump pulse
//   redirect_pc    in   branch/jump target
//   trap_valid     in   trap entry / mret pulse (wins over redirect)
//   trap_pc        in   trap target, low two bits dropped
//   pc_out         out  PC offered to the IFU
//   pc_valid       out  pc_out is valid
//   ifu_ready      in   IFU accepts pc_out
//   flush          out  one-cycle pulse: IFU drops in-flight work
//   misalign       out  one-cycle pulse: redirect target misaligned
//   misalign_pc    out  last misaligned target, held
module pc_gen
  import pc_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEF,
  parameter logic [31:0] PC_STEP      = PC_STEP_DEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        trap_valid,
  input  logic [31:0] trap_pc,
  output logic [31:0] pc_out,
  output logic        pc_valid,
  input  logic        ifu_ready,
  output logic        flush,
  output logic        misalign,
  output logic [31:0] misalign_pc
);

  state_t      state;
  logic [31:0] pc_q;
  logic        accept;

  // pc_valid is registered, so accept depends on no combinational input path
  // to any output.
  assign accept = pc_valid && ifu_ready;
  assign pc_out = pc_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= BOOT;
      pc_q        <= RESET_VECTOR;
      pc_valid    <= 1'b0;
      flush       <= 1'b0;
      misalign    <= 1'b0;
      misalign_pc <= '0;
    end else begin
      // Pulses default low; each branch below raises what it needs.
      flush    <= 1'b0;
      misalign <= 1'b0;
      if (trap_valid) begin
        // Trap wins in every state and is the only way out of HALT.
        pc_q     <= {trap_pc[31:2], ALIGN_OK};
        flush    <= 1'b1;
        pc_valid <= 1'b1;
        state    <= RUN;
      end else if (redirect_valid && state != HALT) begin
        flush <= 1'b1;
        if (is_aligned(redirect_pc)) begin
          // Any same-cycle accept is cancelled by the flush; target wins.
          pc_q     <= redirect_pc;
          pc_valid <= 1'b1;
          state    <= RUN;
        end else begin
          // Keep pc_q; fetch stops until a trap supplies a new target.
          misalign    <= 1'b1;
          misalign_pc <= redirect_pc;
          pc_valid    <= 1'b0;
          state       <= HALT;
        end
      end else begin
        case (state)
          BOOT: begin
            pc_valid <= 1'b1;
            state    <= RUN;
          end
          RUN: begin
            pc_valid <= 1'b1;
            if (accept) pc_q <= pc_q + PC_STEP;
          end
          HALT: begin
            pc_valid <= 1'b0;
          end
          default: begin
            pc_valid <= 1'b0;
            state    <= BOOT;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
module tb_pc_gen;

  localparam logic [31:0] RV = 32'h3000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic        v;
    logic        f;
    logic        m;
  } obs_t;

  typedef struct packed {
    logic        rdy;
    logic        rv;
    logic [31:0] rpc;
    logic        tv;
    logic [31:0] tpc;
  } stim_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        trap_valid = 1'b0;
  logic [31:0] trap_pc = '0;
  logic [31:0] pc_out;
  logic        pc_valid;
  logic        ifu_ready = 1'b0;
  logic        flush;
  logic        misalign;
  logic [31:0] misalign_pc;

  obs_t exp_q[$];
  int   vectors = 0;
  int   errors  = 0;

  pc_gen dut (
    .clock          (clock),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .trap_valid     (trap_valid),
    .trap_pc        (trap_pc),
    .pc_out         (pc_out),
    .pc_valid       (pc_valid),
    .ifu_ready      (ifu_ready),
    .flush          (flush),
    .misalign       (misalign),
    .misalign_pc    (misalign_pc)
  );

  always #5 clock = ~clock;

  task automatic drive(input stim_t s);
    ifu_ready      = s.rdy;
    redirect_valid = s.rv;
    redirect_pc    = s.rpc;
    trap_valid     = s.tv;
    trap_pc        = s.tpc;
  endtask

  // Reset across one edge, released 1 time unit after a rising edge.
  task automatic do_reset();
    drive('{1'b0, 1'b0, 32'h0, 1'b0, 32'h0});
    reset = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    obs_t got, want;
    #3 reset = 1'b0;
    #1;
    exp_q.push_back('{RV, 1'b0, 1'b0, 1'b0});
    got = {pc_out, pc_valid, flush, misalign};
    want = exp_q.pop_front();
    vectors++;
    if (got !== want) begin
      errors++;
      $display("FAIL reset_state got=%h want=%h", got, want);
    end
    vectors++;
    if (misalign_pc !== 32'h0) begin
      errors++;
      $display("FAIL reset_misalign_pc got=%h want=0", misalign_pc);
    end
    @(posedge clock); #1;
    reset = 1'b1;
  endtask

  task automatic test_sequential();
    obs_t got, want;
    drive('{1'b1, 1'b0, 32'h0, 1'b0, 32'h0});
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back('{RV + 32'(4 * i), 1'b1, 1'b0, 1'b0});
      @(posedge clock); #1;
      got = {pc_out, pc_valid, flush, misalign};
      want = exp_q.pop_front();
      vectors++;
      if (got !== want) begin
        errors++;
        $display("FAIL sequential[%0d] got=%h want=%h", i, got, want);
      end
    end
  endtask

  task automatic test_stall();
    obs_t got, want;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      // ready high for first 3 edges, low for 5 stall edges, high again
      drive('{(i < 3 || i == 8), 1'b0, 32'h0, 1'b0, 32'h0});
      if (i < 3)       exp_q.push_back('{RV + 32'(4 * i), 1'b1, 1'b0, 1'b0});
      else if (i < 8)  exp_q.push_back('{RV + 32'h8, 1'b1, 1'b0, 1'b0});
      else             exp_q.push_back('{RV + 32'hC, 1'b1, 1'b0, 1'b0});
      @(posedge clock); #1;
      got = {pc_out, pc_valid, flush, misalign};
      want = exp_q.pop_front();
      vectors++;
      if (got !== want) begin
        errors++;
        $display("FAIL stall[%0d] got=%h want=%h", i, got, want);
      end
    end
  endtask

  task automatic test_redirect();
    obs_t got, want;
    stim_t s[3] = '{
      '{1'b1, 1'b1, 32'h8000_0100, 1'b0, 32'h0},
      '{1'b1, 1'b0, 32'h0, 1'b0, 32'h0},
      '{1'b1, 1'b0, 32'h0, 1'b0, 32'h0}};
    obs_t e[3] = '{
      '{32'h8000_0100, 1'b1, 1'b1, 1'b0},
      '{32'h8000_0104, 1'b1, 1'b0, 1'b0},
      '{32'h8000_0108, 1'b1, 1'b0, 1'b0}};
    for (int i = 0; i < 3; i++) begin
      drive(s[i]);
      exp_q.push_back(e[i]);
      @(posedge clock); #1;
      got = {pc_out, pc_valid, flush, misalign};
      want = exp_q.pop_front();
      vectors++;
      if (got !== want) begin
        errors++;
        $display("FAIL redirect[%0d] got=%h want=%h", i, got, want);
      end
    end
  endtask

  task automatic test_trap_priority();
    obs_t got, want;
    stim_t s[2] = '{
      '{1'b1, 1'b1, 32'h8000_0200, 1'b1, 32'h8000_0003},
      '{1'b1, 1'b0, 32'h0, 1'b0, 32'h0}};
    obs_t e[2] = '{
      '{32'h8000_0000, 1'b1, 1'b1, 1'b0},
      '{32'h8000_0004, 1'b1, 1'b0, 1'b0}};
    for (int i = 0; i < 2; i++) begin
      drive(s[i]);
      exp_q.push_back(e[i]);
      @(posedge clock); #1;
      got = {pc_out, pc_valid, flush, misalign};
      want = exp_q.pop_front();
      vectors++;
      if (got !== want) begin
        errors++;
        $display("FAIL trap_priority[%0d] got=%h want=%h", i, got, want);
      end
    end
  endtask

  task automatic test_back_to_back();
    obs_t got, want;
    stim_t s[3] = '{
      '{1'b1, 1'b1, 32'h8000_0300, 1'b0, 32'h0},
      '{1'b1, 1'b1, 32'h8000_0400, 1'b0, 32'h0},
      '{1'b1, 1'b0, 32'h0, 1'b0, 32'h0}};
    obs_t e[3] = '{
      '{32'h8000_0300, 1'b1, 1'b1, 1'b0},
      '{32'h8000_0400, 1'b1, 1'b1, 1'b0},
      '{32'h8000_0404, 1'b1, 1'b0, 1'b0}};
    for (int i = 0; i < 3; i++) begin
      drive(s[i]);
      exp_q.push_back(e[i]);
      @(posedge clock); #1;
      got = {pc_out, pc_valid, flush, misalign};
      want = exp_q.pop_front();
      vectors++;
      if (got !== want) begin
        errors++;
        $display("FAIL back_to_back[%0d] got=%h want=%h", i, got, want);
      end
    end
  endtask

  task automatic test_misalign();
    obs_t got, want;
    stim_t s[5] = '{
      '{1'b1, 1'b1, 32'h8000_0102, 1'b0, 32'h0},
      '{1'b1, 1'b0, 32'h0, 1'b0, 32'h0},
      '{1'b1, 1'b1, 32'h8000_0500, 1'b0, 32'h0},
      '{1'b1, 1'b0, 32'h0, 1'b1, 32'h8000_1000},
      '{1'b1, 1'b0, 32'h0, 1'b0, 32'h0}};
    obs_t e[5] = '{
      '{32'h8000_0404, 1'b0, 1'b1, 1'b1},
      '{32'h8000_0404, 1'b0, 1'b0, 1'b0},
      '{32'h8000_0404, 1'b0, 1'b0, 1'b0},
      '{32'h8000_1000, 1'b1, 1'b1, 1'b0},
      '{32'h8000_1004, 1'b1, 1'b0, 1'b0}};
    for (int i = 0; i < 5; i++) begin
      drive(s[i]);
      exp_q.push_back(e[i]);
      @(posedge clock); #1;
      got = {pc_out, pc_valid, flush, misalign};
      want = exp_q.pop_front();
      vectors++;
      if (got !== want) begin
        errors++;
        $display("FAIL misalign[%0d] got=%h want=%h", i, got, want);
      end
      vectors++;
      if (misalign_pc !== 32'h8000_0102) begin
        errors++;
        $display("FAIL misalign_pc[%0d] got=%h want=80000102", i, misalign_pc);
      end
    end
  endtask

  task automatic test_wrap();
    obs_t got, want;
    stim_t s[3] = '{
      '{1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0},
      '{1'b1, 1'b0, 32'h0, 1'b0, 32'h0},
      '{1'b1, 1'b0, 32'h0, 1'b0, 32'h0}};
    obs_t e[3] = '{
      '{32'hFFFF_FFFC, 1'b1, 1'b1, 1'b0},
      '{32'h0000_0000, 1'b1, 1'b0, 1'b0},
      '{32'h0000_0004, 1'b1, 1'b0, 1'b0}};
    for (int i = 0; i < 3; i++) begin
      drive(s[i]);
      exp_q.push_back(e[i]);
      @(posedge clock); #1;
      got = {pc_out, pc_valid, flush, misalign};
      want = exp_q.pop_front();
      vectors++;
      if (got !== want) begin
        errors++;
        $display("FAIL wrap[%0d] got=%h want=%h", i, got, want);
      end
    end
  endtask

  task automatic test_async_reset();
    obs_t got, want;
    // Start a flush, then assert reset mid-cycle while it is high.
    drive('{1'b1, 1'b1, 32'h8000_0600, 1'b0, 32'h0});
    @(posedge clock); #1;
    drive('{1'b1, 1'b0, 32'h0, 1'b0, 32'h0});
    #2 reset = 1'b0;
    #1;
    exp_q.push_back('{RV, 1'b0, 1'b0, 1'b0});
    got = {pc_out, pc_valid, flush, misalign};
    want = exp_q.pop_front();
    vectors++;
    if (got !== want) begin
      errors++;
      $display("FAIL async_reset got=%h want=%h", got, want);
    end
    vectors++;
    if (misalign_pc !== 32'h0) begin
      errors++;
      $display("FAIL async_reset_misalign_pc got=%h want=0", misalign_pc);
    end
    @(posedge clock); #1;
    reset = 1'b1;
    exp_q.push_back('{RV, 1'b1, 1'b0, 1'b0});
    @(posedge clock); #1;
    got = {pc_out, pc_valid, flush, misalign};
    want = exp_q.pop_front();
    vectors++;
    if (got !== want) begin
      errors++;
      $display("FAIL async_reset_release got=%h want=%h", got, want);
    end
  endtask

  task automatic test_boot_redirect();
    obs_t got, want;
    stim_t s[2] = '{
      '{1'b1, 1'b1, 32'h8000_0800, 1'b0, 32'h0},
      '{1'b1, 1'b0, 32'h0, 1'b0, 32'h0}};
    obs_t e[2] = '{
      '{32'h8000_0800, 1'b1, 1'b1, 1'b0},
      '{32'h8000_0804, 1'b1, 1'b0, 1'b0}};
    do_reset();
    for (int i = 0; i < 2; i++) begin
      drive(s[i]);
      exp_q.push_back(e[i]);
      @(posedge clock); #1;
      got = {pc_out, pc_valid, flush, misalign};
      want = exp_q.pop_front();
      vectors++;
      if (got !== want) begin
        errors++;
        $display("FAIL boot_redirect[%0d] got=%h want=%h", i, got, want);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_trap_priority();
    test_back_to_back();
    test_misalign();
    test_wrap();
    test_async_reset();
    test_boot_redirect();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #20000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1);
  end

endmodule
